cart_load_ctrl: RTL and testbench

- Sequences cartridge image download from hps_io into the 32 KB cartridge ROM dpram (write port A).
- Decodes bank-switch scheme and SuperChip enable from the file extension and measures image size.
- Holds the A2601 core in reset during and briefly after a load, then releases it.
- Sits between hps_io, the ROM dpram and A2601top, replacing the ad-hoc download/extension logic in the top level.

---
 rtl/cart_pkg.sv | 42 ++++
 rtl/cart_load_ctrl_ext_decode.sv | 24 ++
 rtl/cart_load_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_cart_load_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
// Shared types for the cartridge loader: FSM states, bank-switch codes
// and the file-extension to bank-switch mapping.
package cart_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        RUN    = 2'd1,
        LOAD   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [3:0] BS_NONE = 4'd0;
    localparam logic [3:0] BS_F8   = 4'd1;
    localparam logic [3:0] BS_F6   = 4'd2;
    localparam logic [3:0] BS_FE   = 4'd3;
    localparam logic [3:0] BS_E0   = 4'd4;
    localparam logic [3:0] BS_3F   = 4'd5;
    localparam logic [3:0] BS_F4   = 4'd6;
    localparam logic [3:0] BS_P2   = 4'd7;
    localparam logic [3:0] BS_FA   = 4'd8;
    localparam logic [3:0] BS_CV   = 4'd9;

    // Maps an aligned three-character extension (".F8" etc.) to a scheme.
    function automatic logic [3:0] ext_to_bs(input logic [23:0] ext);
        logic [3:0] code;
        code = BS_NONE;
        case (ext)
            ".F8":   code = BS_F8;
            ".F6":   code = BS_F6;
            ".FE":   code = BS_FE;
            ".E0":   code = BS_E0;
            ".3F":   code = BS_3F;
            ".F4":   code = BS_F4;
            ".P2":   code = BS_P2;
            ".FA":   code = BS_FA;
            ".CV":   code = BS_CV;
            default: code = BS_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/cart_load_ctrl_ext_decode.sv
// Combinational extension alignment plus bank-switch / SuperChip decode.
module cart_ext_decode
    import cart_pkg::*;
(
    input  logic [31:0] file_ext,
    input  logic [1:0]  sc_mode,
    output logic [3:0]  bs_code,
    output logic        sc_sel
);

    logic [23:0] ext;

    // Align the extension on its dot, then decode scheme and SuperChip choice.
    always_comb begin
        ext     = (file_ext[23:16] == ".") ? file_ext[23:0] : file_ext[31:8];
        bs_code = ext_to_bs(ext);
        case (sc_mode)
            2'd1:    sc_sel = 1'b0;
            2'd2:    sc_sel = 1'b1;
            default: sc_sel = (ext[7:0] == "S");
        endcase
    end

endmodule

// File: rtl/cart_load_ctrl.sv
// Cartridge download sequencer: writes hps_io bytes into the ROM dpram,
// latches bank-switch / SuperChip settings and holds the core in reset
// around a load. Optional macro CART_AUTO_BS_EN enables size-based
// bank-switch auto-detection when the extension gives no scheme.
module cart_load_ctrl
    import cart_pkg::*;
#(
    parameter int ADDR_W      = 15,
    parameter int HOLD_CYCLES = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [31:0]       ioctl_file_ext,
    input  logic [1:0]        sc_mode,
    output logic              ioctl_wait,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [7:0]        rom_wdata,
    output logic [3:0]        force_bs,
    output logic              sc,
    output logic [16:0]       rom_size,
    output logic              core_reset,
    output logic              load_err
);

    localparam int          CNT_W     = $clog2(HOLD_CYCLES + 1);
    localparam logic [24:0] ROM_BYTES = 25'(1) << ADDR_W;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d;
    logic                dl_q, dl_d;
    logic [3:0]          force_bs_q, force_bs_d;
    logic                sc_q, sc_d;
    logic                sc_pend_q, sc_pend_d;
    logic [16:0]         acc_q, acc_d;
    logic [16:0]         rom_size_q, rom_size_d;
    logic                load_err_q, load_err_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [7:0]          wdata_q, wdata_d;

    logic [3:0]          dec_bs;
    logic                dec_sc;
    logic                dl_rise;
    logic                dl_fall;
    logic                addr_ok;
    logic [16:0]         addr_p1;

    cart_ext_decode u_ext_decode (
        .file_ext (ioctl_file_ext),
        .sc_mode  (sc_mode),
        .bs_code  (dec_bs),
        .sc_sel   (dec_sc)
    );

    // Next-state logic: load sequencing, write pipeline, size tracking and hold countdown.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        dl_d       = ioctl_download;
        force_bs_d = force_bs_q;
        sc_d       = sc_q;
        sc_pend_d  = sc_pend_q;
        acc_d      = acc_q;
        rom_size_d = rom_size_q;
        load_err_d = load_err_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        dl_rise = ioctl_download & ~dl_q;
        dl_fall = ~ioctl_download & dl_q;
        addr_ok = (ioctl_addr < ROM_BYTES);
        addr_p1 = 17'(ioctl_addr[ADDR_W-1:0]) + 17'd1;

        case (state_q)
            HOLD: begin
                if (dl_rise) begin
                    state_d = LOAD;
                end else if (hold_cnt_q <= CNT_W'(1)) begin
                    state_d    = RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_W'(1);
                end
            end
            RUN: begin
                if (dl_rise) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (ioctl_wr) begin
                    if (addr_ok) begin
                        we_d    = 1'b1;
                        waddr_d = ioctl_addr[ADDR_W-1:0];
                        wdata_d = ioctl_dout;
                        if (addr_p1 > acc_q) begin
                            acc_d = addr_p1;
                        end
                    end else begin
                        load_err_d = 1'b1;
                    end
                end
                if (dl_fall) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                rom_size_d = acc_q;
                sc_d       = sc_pend_q;
`ifdef CART_AUTO_BS_EN
                if (force_bs_q == BS_NONE) begin
                    case (acc_q)
                        17'd8192:  force_bs_d = BS_F8;
                        17'd16384: force_bs_d = BS_F6;
                        17'd32768: force_bs_d = BS_F4;
                        default:   force_bs_d = BS_NONE;
                    endcase
                end
`endif
                hold_cnt_d = CNT_W'(HOLD_CYCLES);
                state_d    = HOLD;
            end
            default: begin
                state_d = HOLD;
            end
        endcase

        // A new load latches its settings and starts with a clean size and error flag.
        if (dl_rise && (state_q == HOLD || state_q == RUN)) begin
            force_bs_d = dec_bs;
            sc_pend_d  = dec_sc;
            acc_d      = '0;
            load_err_d = 1'b0;
        end
    end

    // State register; reset aborts any load and restarts the hold countdown.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= HOLD;
            hold_cnt_q <= CNT_W'(HOLD_CYCLES);
            dl_q       <= 1'b0;
            force_bs_q <= BS_NONE;
            sc_q       <= 1'b0;
            sc_pend_q  <= 1'b0;
            acc_q      <= '0;
            rom_size_q <= '0;
            load_err_q <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            dl_q       <= dl_d;
            force_bs_q <= force_bs_d;
            sc_q       <= sc_d;
            sc_pend_q  <= sc_pend_d;
            acc_q      <= acc_d;
            rom_size_q <= rom_size_d;
            load_err_q <= load_err_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign rom_we     = we_q;
    assign ioctl_wait = we_q;
    assign rom_waddr  = waddr_q;
    assign rom_wdata  = wdata_q;
    assign force_bs   = force_bs_q;
    assign sc         = sc_q;
    assign rom_size   = rom_size_q;
    assign load_err   = load_err_q;
    assign core_reset = (state_q != RUN);

endmodule

// File: tb/tb_cart_load_ctrl.sv
// Directed self-checking bench for cart_load_ctrl.
`timescale 1ns/1ps
module tb_cart_load_ctrl;

`ifdef CART_AUTO_BS_EN
    localparam logic [3:0] EXP_BIN_16K = 4'd2;
`else
    localparam logic [3:0] EXP_BIN_16K = 4'd0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ioctl_download = 1'b0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic [31:0] ioctl_file_ext = '0;
    logic [1:0]  sc_mode = '0;
    logic        ioctl_wait;
    logic        rom_we;
    logic [14:0] rom_waddr;
    logic [7:0]  rom_wdata;
    logic [3:0]  force_bs;
    logic        sc;
    logic [16:0] rom_size;
    logic        core_reset;
    logic        load_err;

    int checkCount = 0;
    int errorCount = 0;

    cart_load_ctrl dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_file_ext (ioctl_file_ext),
        .sc_mode        (sc_mode),
        .ioctl_wait     (ioctl_wait),
        .rom_we         (rom_we),
        .rom_waddr      (rom_waddr),
        .rom_wdata      (rom_wdata),
        .force_bs       (force_bs),
        .sc             (sc),
        .rom_size       (rom_size),
        .core_reset     (core_reset),
        .load_err       (load_err)
    );

    always #5 clk_sys = ~clk_sys;

    // Guards against a hung run.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: actual timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: actual 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Ticks until core_reset drops and checks how many cycles that took.
    task automatic waitCoreRelease(input string tag, input int expected);
        int n;
        n = 0;
        while (core_reset === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checkOutput(tag, n, expected);
    endtask

    // One byte strobe; checks the registered ROM write one cycle later.
    task automatic applyStimulus(input logic [24:0] addr, input logic [7:0] data, input logic expectWrite);
        ioctl_wr   = 1'b1;
        ioctl_addr = addr;
        ioctl_dout = data;
        tick();
        ioctl_wr = 1'b0;
        if (expectWrite)
            checkOutput("rom_write", {7'd0, ioctl_wait, rom_we, rom_waddr, rom_wdata},
                        {7'd0, 1'b1, 1'b1, addr[14:0], data});
        else
            checkOutput("rom_no_write", {30'd0, ioctl_wait, rom_we}, 32'd0);
        tick();
    endtask

    task automatic startDownload(input logic [31:0] ext, input logic [1:0] mode);
        ioctl_file_ext = ext;
        sc_mode        = mode;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic endDownload(input string tag, input int expSize, input logic [3:0] expBs, input logic expSc);
        ioctl_download = 1'b0;
        tick();
        waitCoreRelease({tag, "_release"}, 17);
        checkOutput({tag, "_size"}, 32'(rom_size), 32'(expSize));
        checkOutput({tag, "_bs"}, 32'(force_bs), 32'(expBs));
        checkOutput({tag, "_sc"}, 32'(sc), 32'(expSc));
    endtask

    initial begin
        $display("[TB] cart_load_ctrl bench start");

        // Reset state and initial hold.
        repeat (3) tick();
        checkOutput("rst_outputs", {force_bs, sc, rom_size, load_err, rom_we, ioctl_wait, core_reset},
                    {4'd0, 1'b0, 17'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        reset_n = 1'b1;
        checkOutput("rst_core_reset", 32'(core_reset), 32'd1);
        waitCoreRelease("rst_release", 16);

        // ".F8", 8192 sequential bytes.
        startDownload(32'h002E4638, 2'd0);
        checkOutput("f8_core_reset", 32'(core_reset), 32'd1);
        checkOutput("f8_bs_latched", 32'(force_bs), 32'd1);
        for (int i = 0; i < 8192; i++)
            applyStimulus(25'(i), 8'(i) ^ 8'h5A, 1'b1);
        checkOutput("f8_we_idle", 32'(rom_we), 32'd0);
        endDownload("f8", 8192, 4'd1, 1'b0);

        // "BIN", 16384 bytes: scheme only from auto-detect.
        startDownload(32'h0042494E, 2'd0);
        checkOutput("bin_bs_latched", 32'(force_bs), 32'd0);
        for (int i = 0; i < 16384; i++)
            applyStimulus(25'(i), 8'(i >> 3), 1'b1);
        endDownload("bin16k", 16384, EXP_BIN_16K, 1'b0);

        // SuperChip by trailing "S", non-sequential addresses.
        startDownload(32'h42495300, 2'd0);
        applyStimulus(25'd5, 8'hA5, 1'b1);
        applyStimulus(25'd2, 8'h3C, 1'b1);
        endDownload("bis_auto", 6, 4'd0, 1'b1);

        // Same file with SuperChip disabled, zero-byte load.
        startDownload(32'h42495300, 2'd1);
        endDownload("bis_off_empty", 0, 4'd0, 1'b0);

        // Mode 3 behaves as auto.
        startDownload(32'h42495300, 2'd3);
        applyStimulus(25'd0, 8'h11, 1'b1);
        endDownload("bis_mode3", 1, 4'd0, 1'b1);

        // Forced SuperChip on a plain "BIN".
        startDownload(32'h0042494E, 2'd2);
        applyStimulus(25'd9, 8'h99, 1'b1);
        endDownload("bin_sc_on", 10, 4'd0, 1'b1);

        // ".FE" with an out-of-range strobe and the top byte.
        startDownload(32'h002E4645, 2'd0);
        applyStimulus(25'd0, 8'h01, 1'b1);
        applyStimulus(25'h8000, 8'hEE, 1'b0);
        checkOutput("oor_err_set", 32'(load_err), 32'd1);
        applyStimulus(25'h7FFF, 8'h7F, 1'b1);
        endDownload("fe_full", 32768, 4'd3, 1'b0);
        checkOutput("oor_err_sticky", 32'(load_err), 32'd1);

        // Next download clears the error.
        startDownload(32'h002E4530, 2'd0);
        checkOutput("e0_err_clear", 32'(load_err), 32'd0);
        endDownload("e0_empty", 0, 4'd4, 1'b0);

        // Reset in the middle of a ".3F" load.
        startDownload(32'h002E3346, 2'd0);
        checkOutput("3f_bs_latched", 32'(force_bs), 32'd5);
        for (int i = 0; i < 100; i++)
            applyStimulus(25'(i), 8'(i), 1'b1);
        ioctl_wr   = 1'b1;
        ioctl_addr = 25'd100;
        tick();
        ioctl_wr = 1'b0;
        reset_n  = 1'b0;
        #1;
        checkOutput("abort_outputs", {force_bs, sc, rom_size, load_err, rom_we, ioctl_wait, core_reset},
                    {4'd0, 1'b0, 17'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        ioctl_download = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        waitCoreRelease("abort_release", 16);

        // Fresh load after the abort.
        startDownload(32'h002E4636, 2'd0);
        for (int i = 0; i < 10; i++)
            applyStimulus(25'(i), 8'(i + 1), 1'b1);
        endDownload("f6_after_abort", 10, 4'd2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
